rf_port_arbiter: RTL

- Shares the 64-entry x 64-bit register file (2 read ports, 1 write port) between NUM_REQ read requesters and two write-back sources (ALU, memory).
- Sits between the issue/writeback logic and the register file. Drives the file's read_en, raddr_0/1, write_en, waddr and wdata.
- Returns read data one cycle after grant, tagged with the requester id.
- Forwards same-cycle write data to reads of the same address.

---
 rtl/rf_port_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rf_port_arbiter.sv
// Register-file port arbiter: round-robin shares two read ports among NUM_REQ requesters,
// arbitrates ALU/memory write-back with starvation promotion, and forwards same-cycle writes.
module rf_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 64,
   parameter int ID_W       = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      rsp0_valid,
   output logic [ID_W-1:0]           rsp0_id,
   output logic [DATA_W-1:0]         rsp0_data,
   output logic                      rsp1_valid,
   output logic [ID_W-1:0]           rsp1_id,
   output logic [DATA_W-1:0]         rsp1_data,
   input  logic                      alu_wvalid,
   input  logic [ADDR_W-1:0]         alu_waddr,
   input  logic [DATA_W-1:0]         alu_wdata,
   output logic                      alu_wready,
   input  logic                      mem_wvalid,
   input  logic [ADDR_W-1:0]         mem_waddr,
   input  logic [DATA_W-1:0]         mem_wdata,
   output logic                      mem_wready,
   output logic [1:0]                rf_read_en,
   output logic [ADDR_W-1:0]         rf_raddr_0,
   output logic [ADDR_W-1:0]         rf_raddr_1,
   input  logic [DATA_W-1:0]         rf_rdata_0,
   input  logic [DATA_W-1:0]         rf_rdata_1,
   output logic                      rf_write_en,
   output logic [ADDR_W-1:0]         rf_waddr,
   output logic [DATA_W-1:0]         rf_wdata
);

   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic              g0, g1;
   logic [ID_W-1:0]   g0_idx, g1_idx;
   logic [ADDR_W-1:0] a0, a1;
   logic              cnt_full, mem_win, alu_win;

   logic              rsp0_valid_q, rsp1_valid_q;
   logic [ID_W-1:0]   rsp0_id_q, rsp1_id_q;
   logic [DATA_W-1:0] rsp0_data_q, rsp1_data_q;

   // Outputs are gated by reset so they drop to zero the moment reset rises.
   always_comb begin : read_arb
      int              idx;
      logic [ID_W-1:0] sel;
      g0     = 1'b0;
      g1     = 1'b0;
      g0_idx = '0;
      g1_idx = '0;
      idx    = 0;
      sel    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         sel = ID_W'(idx);
         if (req_valid[sel] && !reset) begin
            if (!g0) begin
               g0     = 1'b1;
               g0_idx = sel;
            end else if (!g1) begin
               g1     = 1'b1;
               g1_idx = sel;
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (g0) req_ready[g0_idx] = 1'b1;
      if (g1) req_ready[g1_idx] = 1'b1;
   end

   assign a0         = g0 ? req_addr[g0_idx*ADDR_W +: ADDR_W] : '0;
   assign a1         = g1 ? req_addr[g1_idx*ADDR_W +: ADDR_W] : '0;
   assign rf_read_en = {g1, g0};
   assign rf_raddr_0 = a0;
   assign rf_raddr_1 = a1;

   // Pointer moves past the last granted requester.
   always_comb begin
      ptr_d = ptr_q;
      if (g1) begin
         ptr_d = (g1_idx == ID_W'(NUM_REQ - 1)) ? '0 : g1_idx + 1'b1;
      end else if (g0) begin
         ptr_d = (g0_idx == ID_W'(NUM_REQ - 1)) ? '0 : g0_idx + 1'b1;
      end
   end

   assign cnt_full = (starve_q == CNT_W'(STARVE_MAX));
   assign mem_win  = !reset && mem_wvalid && (!alu_wvalid || cnt_full);
   assign alu_win  = !reset && alu_wvalid && !mem_win;

   always_comb begin
      starve_d = starve_q;
      if (!mem_wvalid || mem_win) begin
         starve_d = '0;
      end else if (alu_win && !cnt_full) begin
         starve_d = starve_q + 1'b1;
      end
   end

   assign alu_wready  = alu_win;
   assign mem_wready  = mem_win;
   assign rf_write_en = alu_win | mem_win;
   assign rf_waddr    = mem_win ? mem_waddr : (alu_win ? alu_waddr : '0);
   assign rf_wdata    = mem_win ? mem_wdata : (alu_win ? alu_wdata : '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q        <= '0;
         starve_q     <= '0;
         rsp0_valid_q <= 1'b0;
         rsp0_id_q    <= '0;
         rsp0_data_q  <= '0;
         rsp1_valid_q <= 1'b0;
         rsp1_id_q    <= '0;
         rsp1_data_q  <= '0;
      end else begin
         ptr_q        <= ptr_d;
         starve_q     <= starve_d;
         rsp0_valid_q <= g0;
         rsp0_id_q    <= g0 ? g0_idx : '0;
         rsp1_valid_q <= g1;
         rsp1_id_q    <= g1 ? g1_idx : '0;
         // A write landing this edge supersedes the file's stale read value.
         rsp0_data_q  <= !g0 ? '0 : ((rf_write_en && rf_waddr == a0) ? rf_wdata : rf_rdata_0);
         rsp1_data_q  <= !g1 ? '0 : ((rf_write_en && rf_waddr == a1) ? rf_wdata : rf_rdata_1);
      end
   end

   assign rsp0_valid = rsp0_valid_q;
   assign rsp0_id    = rsp0_id_q;
   assign rsp0_data  = rsp0_data_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp1_id    = rsp1_id_q;
   assign rsp1_data  = rsp1_data_q;

endmodule
